// File: rtl/target_dwell_scheduler_pkg.sv
// Shared types and reset constants for the target dwell scheduler.
package sched_pkg;

  typedef struct packed {
    logic signed [15:0] x;
    logic        [15:0] y;
    logic        [15:0] z;
  } target_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    FIRE   = 3'd3,
    COOL   = 3'd4
  } sched_state_t;

  // y must never be zero at the controller, which divides by it
  localparam logic signed [15:0] RST_X = 16'sd0;
  localparam logic        [15:0] RST_Y = 16'd1;
  localparam logic        [15:0] RST_Z = 16'd0;

endpackage

// File: rtl/target_dwell_scheduler_fifo.sv
// Power-of-two target FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module sched_target_fifo
  import sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  target_t                    wr_data,
  output target_t                    rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEPTH);

  target_t       mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic          pop_ok_s;
  logic          push_ok_s;

  assign full      = (count == CNT_MAX);
  assign empty     = (count == {CNTW{1'b0}});
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign rd_data   = mem_r[rd_ptr_r];

  // pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count    <= {CNTW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // storage array; contents are meaningless while empty, so no reset
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wr_data;
  end

endmodule

// File: rtl/target_dwell_scheduler.sv
// Sequences buffered targets into the pan/tilt PWM controller: load, settle,
// fire, cool down. Optional drop counter enabled by SCHED_DROP_CNT_EN.
module target_dwell_scheduler
  import sched_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int SETTLE_FRAMES   = 3,
  parameter int FIRE_CYCLES     = 1_000_000,
  parameter int COOLDOWN_CYCLES = 2_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [15:0]         in_x,
  input  logic        [15:0]         in_y,
  input  logic        [15:0]         in_z,
  input  logic                       in_valid,
  input  logic                       frame_tick,
  input  logic                       enable,
  output logic signed [15:0]         x_coord,
  output logic        [15:0]         y_coord,
  output logic        [15:0]         z_coord,
  output logic                       coord_valid,
  output logic                       fire,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
`ifdef SCHED_DROP_CNT_EN
  ,
  output logic        [15:0]         drop_count
`endif
);

  localparam int CMAX = (FIRE_CYCLES > COOLDOWN_CYCLES) ? FIRE_CYCLES : COOLDOWN_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(SETTLE_FRAMES + 1);
  localparam logic [CW-1:0] FIRE_LAST = CW'(FIRE_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [CW-1:0] CYC_ONE   = CW'(1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SETTLE_FRAMES - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  sched_state_t  state_r;
  sched_state_t  state_s;
  logic [CW-1:0] cyc_r;
  logic [CW-1:0] cyc_s;
  logic [TW-1:0] tick_r;
  logic [TW-1:0] tick_s;
  logic          push_s;
  logic          pop_s;
  logic          accept_s;
  logic          drop_s;
  logic          full_s;
  logic          empty_s;
  target_t       in_tgt_s;
  target_t       head_s;

  assign in_tgt_s = {in_x, in_y, in_z};
  assign push_s   = in_valid && (in_y != 16'd0);
  assign pop_s    = (state_r == IDLE) && enable && !empty_s;
  assign accept_s = push_s && (!full_s || pop_s);
  assign drop_s   = in_valid && !accept_s;

  sched_target_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (in_tgt_s),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (fifo_count)
  );

  // next state; every exit from a state clears the counter it used
  always_comb begin
    state_s = state_r;
    cyc_s   = cyc_r;
    tick_s  = tick_r;
    case (state_r)
      IDLE: begin
        if (pop_s) state_s = LOAD;
        else       state_s = IDLE;
      end
      LOAD: begin
        if (!enable) state_s = COOL;
        else         state_s = SETTLE;
      end
      SETTLE: begin
        if (!enable) begin
          state_s = COOL;
          tick_s  = {TW{1'b0}};
        end else if (frame_tick) begin
          if (tick_r == TICK_LAST) begin
            state_s = FIRE;
            tick_s  = {TW{1'b0}};
          end else begin
            tick_s = tick_r + TICK_ONE;
          end
        end else begin
          state_s = SETTLE;
        end
      end
      FIRE: begin
        if (!enable || (cyc_r == FIRE_LAST)) begin
          state_s = COOL;
          cyc_s   = {CW{1'b0}};
        end else begin
          cyc_s = cyc_r + CYC_ONE;
        end
      end
      COOL: begin
        if (cyc_r == COOL_LAST) begin
          state_s = IDLE;
          cyc_s   = {CW{1'b0}};
        end else begin
          cyc_s = cyc_r + CYC_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cyc_s   = {CW{1'b0}};
        tick_s  = {TW{1'b0}};
      end
    endcase
  end

  // state, counters and registered outputs decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cyc_r       <= {CW{1'b0}};
      tick_r      <= {TW{1'b0}};
      coord_valid <= 1'b0;
      fire        <= 1'b0;
      busy        <= 1'b0;
      x_coord     <= RST_X;
      y_coord     <= RST_Y;
      z_coord     <= RST_Z;
    end else begin
      state_r     <= state_s;
      cyc_r       <= cyc_s;
      tick_r      <= tick_s;
      coord_valid <= (state_s == LOAD);
      fire        <= (state_s == FIRE);
      busy        <= (state_s != IDLE);
      if (pop_s) begin
        x_coord <= head_s.x;
        y_coord <= head_s.y;
        z_coord <= head_s.z;
      end
    end
  end

`ifdef SCHED_DROP_CNT_EN
  // saturating count of rejected detections
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= 16'd0;
    end else if (drop_s && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  logic unused_drop_s;
  assign unused_drop_s = drop_s;
`endif

endmodule
